// File: rtl/ristretto_shift_scheduler_if.sv
// Request/response and shifter-side signals of the Ristretto shift scheduler.
// slave = scheduler side, master = requesters, response consumer and shifter.
interface ristretto_shift_scheduler_if #(parameter int DataWidth = 32);
  logic [1:0]           req_valid_i;
  logic [1:0]           req_ready_o;
  logic [DataWidth-1:0] req0_operand_a_i;
  logic [DataWidth-1:0] req1_operand_a_i;
  logic [4:0]           req0_shamt_i;
  logic [4:0]           req1_shamt_i;
  logic [1:0]           req0_mode_i;
  logic [1:0]           req1_mode_i;
  logic                 rsp_valid_o;
  logic                 rsp_id_o;
  logic [DataWidth-1:0] rsp_result_o;
  logic                 rsp_ready_i;
  logic                 flush_i;
  logic                 sched_busy_o;
  logic [DataWidth-1:0] sshft_operand_a_o;
  logic [4:0]           sshft_operand_b_o;
  logic [1:0]           sshft_mode_o;
  logic                 sshft_en_o;
  logic                 sshft_busy_i;
  logic [DataWidth-1:0] sshft_result_i;

  modport slave (
    input  req_valid_i, req0_operand_a_i, req1_operand_a_i, req0_shamt_i, req1_shamt_i,
           req0_mode_i, req1_mode_i, rsp_ready_i, flush_i, sshft_busy_i, sshft_result_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, sched_busy_o,
           sshft_operand_a_o, sshft_operand_b_o, sshft_mode_o, sshft_en_o
  );

  modport master (
    output req_valid_i, req0_operand_a_i, req1_operand_a_i, req0_shamt_i, req1_shamt_i,
           req0_mode_i, req1_mode_i, rsp_ready_i, flush_i, sshft_busy_i, sshft_result_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, sched_busy_o,
           sshft_operand_a_o, sshft_operand_b_o, sshft_mode_o, sshft_en_o
  );
endinterface

// File: rtl/ristretto_shift_scheduler.sv
// Shares one sequential shifter between two requesters: round-robin grant,
// 0/1-bit shifts resolved combinationally, longer shifts sequenced via en.
module ristretto_shift_scheduler #(
  parameter int DataWidth = 32
) (
  input logic                       clk_i,
  input logic                       rstn_i,
  ristretto_shift_scheduler_if.slave bus
);
  localparam logic [1:0] SHIFT_LEFT   = 2'b00;
  localparam logic [1:0] SHIFT_RIGHT  = 2'b01;
  localparam logic [1:0] SHIFT_ARIGHT = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, CAPT, RESP} state_e;

  state_e               r_state, w_next;
  logic                 r_last_id, r_id, r_run_d1;
  logic [DataWidth-1:0] r_opa, r_result;
  logic [4:0]           r_shamt, r_cnt;
  logic [1:0]           r_mode;

  logic                 w_gid, w_accept, w_fast, w_rsp_valid;
  logic [1:0]           w_grant, w_mode;
  logic [4:0]           w_shamt;
  logic [DataWidth-1:0] w_opa, w_fast_res;

  // r_last_id resets to 1 so a simultaneous first request favours port 0
  always_comb begin
    case (bus.req_valid_i)
      2'b10:   w_gid = 1'b1;
      2'b11:   w_gid = ~r_last_id;
      default: w_gid = 1'b0;
    endcase
    w_accept = (r_state == IDLE) && (|bus.req_valid_i) && !bus.flush_i;
    w_grant  = '0;
    if (w_accept) w_grant[w_gid] = 1'b1;
    w_opa    = w_gid ? bus.req1_operand_a_i : bus.req0_operand_a_i;
    w_shamt  = w_gid ? bus.req1_shamt_i     : bus.req0_shamt_i;
    w_mode   = w_gid ? bus.req1_mode_i      : bus.req0_mode_i;
    w_fast   = (w_shamt < 5'd2) || (w_mode == 2'b11);
    w_fast_res = w_opa;
    if (w_shamt == 5'd1) begin
      case (w_mode)
        SHIFT_LEFT:   w_fast_res = {w_opa[DataWidth-2:0], 1'b0};
        SHIFT_RIGHT:  w_fast_res = {1'b0, w_opa[DataWidth-1:1]};
        SHIFT_ARIGHT: w_fast_res = {w_opa[DataWidth-1], w_opa[DataWidth-1:1]};
        default:      w_fast_res = w_opa;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = w_fast ? RESP : RUN;
        RUN:     if (r_cnt == r_shamt - 5'd1) w_next = CAPT;
        CAPT:    w_next = RESP;
        RESP:    if (bus.rsp_ready_i) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_last_id <= 1'b1;
      r_id      <= 1'b0;
      r_opa     <= '0;
      r_shamt   <= '0;
      r_mode    <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_run_d1  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_run_d1 <= (r_state == RUN);
      if (w_accept) begin
        r_last_id <= w_gid;
        r_id      <= w_gid;
        r_opa     <= w_opa;
        r_shamt   <= w_shamt;
        r_mode    <= w_mode;
        r_cnt     <= '0;
        if (w_fast) r_result <= w_fast_res;
      end
      if (r_state == RUN)  r_cnt    <= r_cnt + 5'd1;
      if (r_state == CAPT) r_result <= bus.sshft_result_i;
    end
  end

  // a flush in RESP withdraws the response in the same cycle, so no handshake slips through
  assign w_rsp_valid           = (r_state == RESP) && !bus.flush_i;
  assign bus.req_ready_o       = w_grant;
  assign bus.rsp_valid_o       = w_rsp_valid;
  assign bus.rsp_id_o          = r_id;
  assign bus.rsp_result_o      = r_result;
  assign bus.sched_busy_o      = (r_state != IDLE);
  assign bus.sshft_en_o        = (r_state == RUN);
  assign bus.sshft_operand_a_o = r_opa;
  assign bus.sshft_operand_b_o = r_shamt;
  assign bus.sshft_mode_o      = r_mode;

  // the shifter may still report busy in the single cycle after a flushed RUN
  a_shifter_idle: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (r_state == IDLE && !r_run_d1) |-> !bus.sshft_busy_i);
endmodule
